// File: rtl/dma_div_scheduler.sv
// ---------------------------------------------------------------------------
// dma_div_scheduler
//
// Shares one signed Q16 divider between NREQ requesters.
// A round-robin arbiter picks one request at a time.
// The divisor is checked for zero.
// The operation is then either answered straight away with a saturated
// result, or sent to the divider.
// In the divider case, the block waits for div_rdy or for a timeout.
// The result goes back to the requester that owns the operation.
// Only one operation is in flight at any time.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   req_valid     per-requester request, held high until accepted
//   req_in1/2     packed 32-bit dividends / divisors, requester i at [32i+31:32i]
//   req_ready     one-hot, one-cycle accept pulse
//   rsp_valid     one-hot, one-cycle result pulse to the owning requester
//   rsp_data      result, non-zero only while rsp_valid is high
//   rsp_err       divide-by-zero or timeout flag, qualified by rsp_valid
//   div_start     one-cycle launch pulse to the divider
//   div_in1/2     divider operands, non-zero only while div_start is high
//   div_out       divider result, qualified by div_rdy
//   div_rdy       divider one-cycle completion pulse
//   busy          high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module dma_div_scheduler #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [32*NREQ-1:0]   req_in1,
   input  logic [32*NREQ-1:0]   req_in2,
   output logic [NREQ-1:0]      req_ready,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [31:0]          rsp_data,
   output logic                 rsp_err,
   output logic                 div_start,
   output logic [31:0]          div_in1,
   output logic [31:0]          div_in2,
   input  logic [31:0]          div_out,
   input  logic                 div_rdy,
   output logic                 busy
);

   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t          state;
   logic [GW-1:0]   last_grant;
   logic [GW-1:0]   grant_q;
   logic [31:0]     op1;
   logic [31:0]     op2;
   logic [TW-1:0]   timer;

   logic            pick_found;
   logic [GW-1:0]   pick_idx;
   logic [31:0]     pick_in1;
   logic [31:0]     pick_in2;
   logic [GW:0]     cand_sum;
   logic [GW-1:0]   cand;
   logic [NREQ-1:0] grant_onehot;
   logic [NREQ-1:0] pick_onehot;

   // Round-robin search.
   // The search starts just after the last served requester and wraps
   // around.
   // The first requester found with req_valid high wins.
   // A requester that drops its request before the grant is skipped here.
   // Nothing else depends on it.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      pick_in1   = '0;
      pick_in2   = '0;
      cand_sum   = '0;
      cand       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand_sum = {1'b0, last_grant} + (GW+1)'(k);
         if (cand_sum >= (GW+1)'(NREQ)) begin
            cand_sum = cand_sum - (GW+1)'(NREQ);
         end
         cand = cand_sum[GW-1:0];
         if (!pick_found && req_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
            pick_in1   = req_in1[{cand, 5'd0} +: 32];
            pick_in2   = req_in2[{cand, 5'd0} +: 32];
         end
      end
   end

   assign pick_onehot  = NREQ'(1) << pick_idx;
   assign grant_onehot = NREQ'(1) << grant_q;
   assign busy         = (state != IDLE);

   // Main scheduler FSM.
   // Every output pulse is registered.
   // Each pulse is cleared by default at the top of every cycle.
   // This keeps the pulses one cycle wide.
   // It also keeps the data buses at zero when they are not qualified.
   //
   // The latched divisor is checked for zero in ISSUE.
   // A zero divisor sends the saturated response straight away.
   // That response shows up one cycle after req_ready.
   // The divider path reaches DONE with the result already on the outputs.
   // So DONE is the single response cycle for both paths.
   // div_rdy is only looked at in WAIT.
   // A late or stray completion pulse therefore cannot disturb anything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= GW'(NREQ - 1);
         grant_q    <= '0;
         op1        <= '0;
         op2        <= '0;
         timer      <= '0;
         req_ready  <= '0;
         rsp_valid  <= '0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
         div_start  <= 1'b0;
         div_in1    <= '0;
         div_in2    <= '0;
      end else begin
         req_ready <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         div_start <= 1'b0;
         div_in1   <= '0;
         div_in2   <= '0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  req_ready <= pick_onehot;
                  grant_q   <= pick_idx;
                  op1       <= pick_in1;
                  op2       <= pick_in2;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (op2 == 32'd0) begin
                  rsp_valid <= grant_onehot;
                  rsp_data  <= op1[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                  rsp_err   <= 1'b1;
                  state     <= DONE;
               end else begin
                  div_start <= 1'b1;
                  div_in1   <= op1;
                  div_in2   <= op2;
                  timer     <= '0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               timer <= timer + TW'(1);
               if (div_rdy) begin
                  rsp_valid <= grant_onehot;
                  rsp_data  <= div_out;
                  rsp_err   <= 1'b0;
                  state     <= DONE;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  rsp_valid <= grant_onehot;
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               last_grant <= grant_q;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/dma_div_scheduler.md
DMA_DIV_SCHEDULER -- requirements
Module: dma_div_scheduler

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing one divider (2..8).
REQ-002 Parameter TIMEOUT, default 64, SHALL set the maximum number of cycles to wait for div_rdy after div_start.
REQ-003 clk  in  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 req_valid  in  NREQ  SHALL carry per-requester operation requests, held high until accepted.
REQ-006 req_in1  in  32*NREQ  SHALL carry packed dividends; requester i occupies bits [32i+31:32i].
REQ-007 req_in2  in  32*NREQ  SHALL carry packed divisors, packed as req_in1.
REQ-008 req_ready  out  NREQ  SHALL be a one-hot, one-cycle accept pulse.
REQ-009 rsp_valid  out  NREQ  SHALL be a one-hot, one-cycle result pulse to the owning requester.
REQ-010 rsp_data  out  32  SHALL carry the result, valid only while any rsp_valid bit is high.
REQ-011 rsp_err  out  1  SHALL flag divide-by-zero or timeout, qualified by rsp_valid.
REQ-012 div_start  out  1  SHALL pulse for one cycle to launch the shared signed Q16 divider.
REQ-013 div_in1, div_in2  out  32 each  SHALL carry operands to the divider, valid while div_start is high.
REQ-014 div_out  in  32  SHALL carry the divider result, qualified by div_rdy.
REQ-015 div_rdy  in  1  SHALL be the divider's one-cycle completion pulse.
REQ-016 busy  out  1  SHALL be high in every state except IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE; only one operation SHALL be outstanding at a time.
REQ-018 In IDLE with any req_valid high, the block SHALL grant the requester selected by round-robin, searching from index last_grant+1 with wrap-around.
REQ-019 In the grant cycle, the block SHALL pulse req_ready[g], latch operands i1 and i2 and the grant index g, and leave IDLE.
REQ-020 If the latched i2 is 0, the block SHALL go directly to DONE without using the divider.
- Result: rsp_data = 32'h7FFFFFFF if i1[31] is 0, else 32'h80000000.
- rsp_err = 1.
REQ-021 Otherwise the block SHALL go to ISSUE.
- ISSUE: div_start = 1, div_in1 = i1, div_in2 = i2 for exactly one cycle; timer cleared; next state WAIT.
REQ-022 In WAIT, the timer SHALL increment each cycle.
- div_rdy high: latch div_out, rsp_err = 0, next state DONE.
- Else, timer == TIMEOUT-1: latch data 0, rsp_err = 1, next state DONE.
REQ-023 div_rdy SHALL be ignored in every state other than WAIT.
REQ-024 In DONE, the block SHALL drive rsp_valid[g] = 1 with the latched data and error for one cycle, set last_grant = g, and return to IDLE.
REQ-025 Timing: req_ready in cycle T, div_start in cycle T+1, rsp_valid in the cycle after div_rdy. A divide-by-zero responds at T+1.
REQ-026 req_ready SHALL never be asserted outside IDLE; requests arriving while busy SHALL wait.
REQ-027 When div_start, req_ready and rsp_valid are not asserted, div_in1/div_in2 and rsp_data SHALL be 0.
REQ-028 The block SHALL not re-grant a requester until its rsp_valid has been issued.
REQ-029 A requester that drops req_valid before acceptance SHALL be skipped without side effects.

Reset
REQ-030 On rst, the block SHALL enter IDLE with last_grant = NREQ-1, timer = 0 and latched operands/data = 0.
REQ-031 On rst, all outputs SHALL be 0: req_ready, rsp_valid, rsp_data, rsp_err, div_start, div_in1, div_in2 and busy.
REQ-032 Reset asserted mid-operation SHALL abandon it with no rsp_valid; a div_rdy arriving after reset SHALL be ignored.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- Single requester 1, in1=6, in2=3; divider model returns 0x00020000 after 50 cycles -> req_ready=4'b0010, div_start one cycle later with div_in1=6/div_in2=3, then rsp_valid=4'b0010, rsp_data=0x00020000, rsp_err=0.
- All 4 requesters valid from reset -> grants in order 0,1,2,3 with one operation in flight; requester 0 re-requesting after its response is granted only after 1,2,3.
- Requester 2, in1=0xFFFFFFF0, in2=0 -> rsp_valid=4'b0100 one cycle after req_ready, rsp_data=0x80000000, rsp_err=1, div_start never asserted.
- Divider model never asserts div_rdy -> rsp_valid exactly TIMEOUT cycles after div_start, rsp_data=0, rsp_err=1; a later request is served normally.
- rst pulsed during WAIT, then a stale div_rdy -> no rsp_valid, busy=0, next request granted normally.
- Spurious div_rdy in IDLE -> no output change.
